decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I decode pipeline stage; the producer side of the ALU control interface.
//  - Accepts a fetched instruction and its PC over a valid/ready handshake.
//  - Decodes it into an rvcpu::alu_op_t, operand selects, a sign-extended immediate and register indices.
//  - Registers the result in one output slot that feeds the execute stage.
// PARAMETERS
//  Width  32  datapath width of PC and immediate; only 32 is supported (RV32I)
// PORTS
//  clk          in   1      system clock; all state updates on rising edge
//  rst          in   1      reset, synchronous, active-high
//  in_valid     in   1      fetch presents in_instr/in_pc
//  in_ready     out  1      stage accepts input this cycle
//  in_instr     in   32     raw instruction word
//  in_pc        in   Width  PC of in_instr
//  flush        in   1      kill held and incoming instruction (branch redirect)
//  out_valid    out  1      decoded bundle valid
//  out_ready    in   1      execute accepts bundle
//  out_alu_op   out  4      rvcpu::alu_op_t
//  out_a_sel    out  2      rvcpu::a_sel_t: RS1 / PC / ZERO
//  out_b_sel    out  1      rvcpu::b_sel_t: RS2 / IMM
//  out_res_sel  out  2      rvcpu::res_sel_t: ALU / LT / LTU / PC4
//  out_imm      out  Width  sign-extended immediate
//  out_rs1      out  5      source register 1 index
//  out_rs2      out  5      source register 2 index
//  out_rd       out  5      destination register index
//  out_rd_we    out  1      register write enable
//  out_pc       out  Width  PC of the decoded instruction
//  out_illegal  out  1      instruction not decodable
// BEHAVIOUR
//  - Reset: out_valid=0; every other registered output is 0.
//  - Latency: 1 cycle. Accept when in_valid&&in_ready; the bundle appears at the next edge.
//  - in_ready = !out_valid || out_ready. This is combinational; there is no skid buffer.
//  - Stall: while out_valid&&!out_ready, all out_* hold bit-stable.
//  - flush (highest priority below rst): out_valid<=0 at the next edge.
//    Any input presented in the same cycle is dropped.
//  - ALU op encodings: ADD=0000, SLL=0001, SRL=0101, SRA=1101, SUB=1000, XOR=0100, OR=0110, AND=0111.
//  - OP (0110011):
//    - funct7 0000000: funct3 selects ADD/SLL/XOR/SRL/OR/AND.
//    - funct7 0100000: SUB (f3=000) or SRA (f3=101).
//    - SLT/SLTU: op=SUB, res_sel=LT/LTU.
//    - Any other funct7/funct3 combination is illegal.
//  - OP-IMM (0010011): b_sel=IMM; the same mapping applies, except there is no SUB.
//    - SLLI requires imm[11:5]=0.
//    - SRLI/SRAI: bit30 selects SRA; other imm[11:5] bits must be 0.
//  - LUI: a_sel=ZERO, ADD, U-imm.
//  - AUIPC: a_sel=PC, ADD, U-imm.
//  - JAL: a_sel=PC, ADD, J-imm, res_sel=PC4.
//  - JALR: a_sel=RS1, ADD, I-imm, res_sel=PC4.
//  - LOAD/STORE: ADD, RS1+I/S-imm. STORE and BRANCH drive rd_we=0.
//  - BRANCH: op=SUB, b_sel=RS2, B-imm.
//  - out_rd_we is forced 0 when rd==x0, for illegal instructions, and when out_valid==0.
//  - Immediates: bit31 sign-extends to Width. B/J immediates have bit0=0. U immediate = instr[31:12]<<12.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    - An illegal instruction is passed downstream with out_illegal=1 and rd_we=0.
//  ILLEGAL_TRAP_EN undefined:
//    - An illegal instruction becomes a NOP: ADD, rd_we=0.
//    - out_illegal is tied 0.
// STRUCTURE
//  Package rvcpu holds:
//    - alu_op_t and its ALU_* constants
//    - opcode_t
//    - a_sel_t, b_sel_t, res_sel_t
//    - imm_type_t (I/S/B/U/J)
//  Sub-module imm_gen (combinational): in_instr, imm_type -> Width-bit immediate.
//  Top level = combinational decoder + output register + handshake logic.
// TESTING
//  1. 0x002081B3 (add x3,x1,x2) -> alu_op=0000, rs1=1, rs2=2, rd=3, b_sel=RS2, rd_we=1, 1 cycle later.
//  2. 0x407302B3 (sub x5,x6,x7) -> alu_op=1000. 0x4030D093 (srai x1,x1,3) -> alu_op=1101, imm=3, b_sel=IMM.
//  3. 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF. 0x12345137 (lui x2) -> imm=0x12345000, a_sel=ZERO.
//  4. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable.
//     Release -> next instruction appears 1 cycle later, none lost or duplicated.
//  5. flush during a stall, and flush concurrent with in_valid -> out_valid=0 next cycle, input dropped.
//     rst mid-stream -> all outputs 0.
//  6. 0x00000000 -> out_illegal=1, rd_we=0 (ILLEGAL_TRAP_EN). Without the macro -> NOP, out_illegal=0.

Source files
------------

// File: rtl/rvcpu_pkg.sv
// Shared RV32I decode types: ALU operations, opcodes, operand/result selects
// and immediate formats, plus small funct3 mapping helpers used by the decoder.
package rvcpu;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SLL = 4'b0001,
        ALU_XOR = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_OR  = 4'b0110,
        ALU_AND = 4'b0111,
        ALU_SUB = 4'b1000,
        ALU_SRA = 4'b1101
    } alu_op_t;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_t;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_t;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_sel_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_LT  = 2'd1,
        RES_LTU = 2'd2,
        RES_PC4 = 2'd3
    } res_sel_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_t;

    // Base-variant ALU op for OP / OP-IMM funct3 (funct7 bit30 clear).
    // SLT/SLTU run through the subtractor; the result select picks the flag.
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SUB;
            3'b011:  op = ALU_SUB;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic res_sel_t res_from_f3(input logic [2:0] f3);
        res_sel_t rs;
        case (f3)
            3'b010:  rs = RES_LT;
            3'b011:  rs = RES_LTU;
            default: rs = RES_ALU;
        endcase
        return rs;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side input handshake, flush, and decoded bundle towards execute.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload stable while valid && !ready.
// slave = the decode stage, master = its environment (fetch + execute).
interface decode_stage_if
    import rvcpu::*;
#(
    parameter int Width = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [Width-1:0] in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    alu_op_t          out_alu_op;
    a_sel_t           out_a_sel;
    b_sel_t           out_b_sel;
    res_sel_t         out_res_sel;
    logic [Width-1:0] out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic             out_rd_we;
    logic [Width-1:0] out_pc;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_alu_op, out_a_sel, out_b_sel, out_res_sel,
               out_imm, out_rs1, out_rs2, out_rd, out_rd_we, out_pc, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_alu_op, out_a_sel, out_b_sel, out_res_sel,
               out_imm, out_rs1, out_rs2, out_rd, out_rd_we, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the RV32I I/S/B/U/J immediate
// layout and sign-extends from instruction bit 31.
module imm_gen
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic [31:0]      instr,
    input  imm_type_t        imm_type,
    output logic [Width-1:0] imm
);
    // Opcode bits never carry immediate data.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[6:0];

    // Format select; B and J offsets are halfword aligned so bit0 is 0.
    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{(Width-12){instr[31]}}, instr[31:20]};
            IMM_S: imm = {{(Width-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{(Width-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {{(Width-32){instr[31]}}, instr[31:12], 12'b0};
            IMM_J: imm = {{(Width-21){instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decoder, one registered output slot and
// valid/ready handshake (no skid buffer, in_ready is combinational).
// Optional feature: ILLEGAL_TRAP_EN -- when defined, illegal instructions are
// forwarded with out_illegal=1; otherwise they become an ADD NOP and
// out_illegal is tied low. Both builds never write rd for illegal words.
module decode_stage
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_idx;

    assign opcode = bus.in_instr[6:0];
    assign f3     = bus.in_instr[14:12];
    assign f7     = bus.in_instr[31:25];
    assign rd_idx = bus.in_instr[11:7];

    alu_op_t   dec_alu_op;
    a_sel_t    dec_a_sel;
    b_sel_t    dec_b_sel;
    res_sel_t  dec_res_sel;
    imm_type_t dec_imm_type;
    logic      dec_imm_en;
    logic      dec_shamt;
    logic      dec_writes_rd;
    logic      dec_illegal;

    // Decode opcode/funct fields into control; illegal words collapse to a NOP.
    always_comb begin
        dec_alu_op    = ALU_ADD;
        dec_a_sel     = A_RS1;
        dec_b_sel     = B_RS2;
        dec_res_sel   = RES_ALU;
        dec_imm_type  = IMM_I;
        dec_imm_en    = 1'b0;
        dec_shamt     = 1'b0;
        dec_writes_rd = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_writes_rd = 1'b1;
                if (f7 == 7'b0000000) begin
                    dec_alu_op  = alu_from_f3(f3);
                    dec_res_sel = res_from_f3(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec_alu_op = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec_alu_op = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_writes_rd = 1'b1;
                dec_b_sel     = B_IMM;
                dec_imm_en    = 1'b1;
                dec_alu_op    = alu_from_f3(f3);
                dec_res_sel   = res_from_f3(f3);
                if (f3 == 3'b001) begin
                    dec_shamt = 1'b1;
                    if (f7 != 7'b0000000) dec_illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    dec_shamt = 1'b1;
                    if (f7[6] || f7[4:0] != 5'b0) dec_illegal = 1'b1;
                    else if (f7[5]) dec_alu_op = ALU_SRA;
                end
            end
            OPC_LUI: begin
                dec_writes_rd = 1'b1;
                dec_a_sel     = A_ZERO;
                dec_b_sel     = B_IMM;
                dec_imm_type  = IMM_U;
                dec_imm_en    = 1'b1;
            end
            OPC_AUIPC: begin
                dec_writes_rd = 1'b1;
                dec_a_sel     = A_PC;
                dec_b_sel     = B_IMM;
                dec_imm_type  = IMM_U;
                dec_imm_en    = 1'b1;
            end
            OPC_JAL: begin
                dec_writes_rd = 1'b1;
                dec_a_sel     = A_PC;
                dec_b_sel     = B_IMM;
                dec_imm_type  = IMM_J;
                dec_imm_en    = 1'b1;
                dec_res_sel   = RES_PC4;
            end
            OPC_JALR: begin
                dec_writes_rd = 1'b1;
                dec_b_sel     = B_IMM;
                dec_imm_en    = 1'b1;
                dec_res_sel   = RES_PC4;
                if (f3 != 3'b000) dec_illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec_writes_rd = 1'b1;
                dec_b_sel     = B_IMM;
                dec_imm_en    = 1'b1;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_illegal = 1'b1;
            end
            OPC_STORE: begin
                dec_b_sel    = B_IMM;
                dec_imm_type = IMM_S;
                dec_imm_en   = 1'b1;
                if (f3[2] || f3 == 3'b011) dec_illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec_alu_op   = ALU_SUB;
                dec_imm_type = IMM_B;
                dec_imm_en   = 1'b1;
                if (f3 == 3'b010 || f3 == 3'b011) dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_alu_op    = ALU_ADD;
            dec_a_sel     = A_RS1;
            dec_b_sel     = B_RS2;
            dec_res_sel   = RES_ALU;
            dec_imm_type  = IMM_I;
            dec_imm_en    = 1'b0;
            dec_shamt     = 1'b0;
            dec_writes_rd = 1'b0;
        end
    end

    logic [Width-1:0] gen_imm;
    logic [Width-1:0] dec_imm;
    logic             dec_rd_we;

    imm_gen #(.Width(Width)) u_imm_gen (
        .instr    (bus.in_instr),
        .imm_type (dec_imm_type),
        .imm      (gen_imm)
    );

    // Shift immediates carry only the shamt; formats without an immediate give 0.
    always_comb begin
        dec_imm = '0;
        if (dec_imm_en) begin
            if (dec_shamt) dec_imm = {{(Width-5){1'b0}}, bus.in_instr[24:20]};
            else           dec_imm = gen_imm;
        end
    end

    assign dec_rd_we = dec_writes_rd && (rd_idx != 5'd0) && !dec_illegal;

    logic             valid_q;
    alu_op_t          alu_op_q;
    a_sel_t           a_sel_q;
    b_sel_t           b_sel_q;
    res_sel_t         res_sel_q;
    logic [Width-1:0] imm_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rd_q;
    logic             rd_we_q;
    logic [Width-1:0] pc_q;

    logic accept;
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Output slot: reset clears, flush kills, otherwise load on accept and hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            alu_op_q  <= ALU_ADD;
            a_sel_q   <= A_RS1;
            b_sel_q   <= B_RS2;
            res_sel_q <= RES_ALU;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            pc_q      <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (bus.in_ready) begin
            valid_q <= bus.in_valid;
            if (accept) begin
                alu_op_q  <= dec_alu_op;
                a_sel_q   <= dec_a_sel;
                b_sel_q   <= dec_b_sel;
                res_sel_q <= dec_res_sel;
                imm_q     <= dec_imm;
                rs1_q     <= bus.in_instr[19:15];
                rs2_q     <= bus.in_instr[24:20];
                rd_q      <= rd_idx;
                rd_we_q   <= dec_rd_we;
                pc_q      <= bus.in_pc;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Illegal flag travels with the bundle so execute can raise the trap.
    always_ff @(posedge clk) begin
        if (rst)                         illegal_q <= 1'b0;
        else if (!bus.flush && accept)   illegal_q <= dec_illegal;
    end

    assign bus.out_illegal = illegal_q;
`else
    assign bus.out_illegal = 1'b0;
`endif

    assign bus.out_valid   = valid_q;
    assign bus.out_alu_op  = alu_op_q;
    assign bus.out_a_sel   = a_sel_q;
    assign bus.out_b_sel   = b_sel_q;
    assign bus.out_res_sel = res_sel_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_rs1     = rs1_q;
    assign bus.out_rs2     = rs2_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_rd_we   = rd_we_q && valid_q;
    assign bus.out_pc      = pc_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, stall, flush, reset.
module tb_decode_stage;
    import rvcpu::*;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

`ifdef ILLEGAL_TRAP_EN
    localparam logic ExpTrap = 1'b1;
`else
    localparam logic ExpTrap = 1'b0;
`endif

    decode_stage_if #(.Width(32)) bus ();

    decode_stage #(.Width(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_alu", bus.out_alu_op, 0);
        chk("rst_imm", bus.out_imm, 0);
        chk("rst_rd", bus.out_rd, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_rd_we", bus.out_rd_we, 0);
        chk("rst_illegal", bus.out_illegal, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;

        // add x3,x1,x2
        drive(32'h002081B3, 32'h100);
        #1 chk("add_in_ready", bus.in_ready, 1);
        tick();
        chk("add_valid", bus.out_valid, 1);
        chk("add_alu", bus.out_alu_op, 4'b0000);
        chk("add_rs1", bus.out_rs1, 1);
        chk("add_rs2", bus.out_rs2, 2);
        chk("add_rd", bus.out_rd, 3);
        chk("add_b_sel", bus.out_b_sel, 0);
        chk("add_a_sel", bus.out_a_sel, 0);
        chk("add_res_sel", bus.out_res_sel, 0);
        chk("add_rd_we", bus.out_rd_we, 1);
        chk("add_pc", bus.out_pc, 32'h100);

        // sub x5,x6,x7
        drive(32'h407302B3, 32'h104);
        tick();
        chk("sub_alu", bus.out_alu_op, 4'b1000);
        chk("sub_rd", bus.out_rd, 5);
        chk("sub_rs1", bus.out_rs1, 6);
        chk("sub_rs2", bus.out_rs2, 7);

        // srai x1,x1,3
        drive(32'h4030D093, 32'h108);
        tick();
        chk("srai_alu", bus.out_alu_op, 4'b1101);
        chk("srai_imm", bus.out_imm, 3);
        chk("srai_b_sel", bus.out_b_sel, 1);
        chk("srai_rd_we", bus.out_rd_we, 1);

        // addi x1,x0,-1
        drive(32'hFFF00093, 32'h10C);
        tick();
        chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        chk("addi_alu", bus.out_alu_op, 4'b0000);
        chk("addi_rs1", bus.out_rs1, 0);

        // lui x2,0x12345
        drive(32'h12345137, 32'h110);
        tick();
        chk("lui_imm", bus.out_imm, 32'h12345000);
        chk("lui_a_sel", bus.out_a_sel, 2);
        chk("lui_rd", bus.out_rd, 2);
        chk("lui_rd_we", bus.out_rd_we, 1);

        // jal x1,+8
        drive(32'h008000EF, 32'h200);
        tick();
        chk("jal_imm", bus.out_imm, 8);
        chk("jal_a_sel", bus.out_a_sel, 1);
        chk("jal_res_sel", bus.out_res_sel, 3);
        chk("jal_pc", bus.out_pc, 32'h200);

        // beq x1,x2,-4
        drive(32'hFE208EE3, 32'h204);
        tick();
        chk("beq_alu", bus.out_alu_op, 4'b1000);
        chk("beq_imm", bus.out_imm, 32'hFFFFFFFC);
        chk("beq_b_sel", bus.out_b_sel, 0);
        chk("beq_rd_we", bus.out_rd_we, 0);

        // sw x2,8(x1)
        drive(32'h0020A423, 32'h208);
        tick();
        chk("sw_imm", bus.out_imm, 8);
        chk("sw_b_sel", bus.out_b_sel, 1);
        chk("sw_rd_we", bus.out_rd_we, 0);

        // slt x4,x5,x6
        drive(32'h0062A233, 32'h20C);
        tick();
        chk("slt_alu", bus.out_alu_op, 4'b1000);
        chk("slt_res_sel", bus.out_res_sel, 1);
        chk("slt_rd", bus.out_rd, 4);

        // OP with funct7=0000001 is not RV32I
        drive(32'h022081B3, 32'h210);
        tick();
        chk("badf7_valid", bus.out_valid, 1);
        chk("badf7_rd_we", bus.out_rd_we, 0);
        chk("badf7_illegal", bus.out_illegal, ExpTrap);

        // addi x0,x0,0 -> rd==x0
        drive(32'h00000013, 32'h214);
        tick();
        chk("nop_rd_we", bus.out_rd_we, 0);
        chk("nop_illegal", bus.out_illegal, 0);

        // all-zero word
        drive(32'h00000000, 32'h218);
        tick();
        chk("zero_illegal", bus.out_illegal, ExpTrap);
        chk("zero_rd_we", bus.out_rd_we, 0);
        chk("zero_alu", bus.out_alu_op, 4'b0000);

        // stall: A held for 3 cycles while B waits
        drive(32'h00500093, 32'h300);
        tick();
        chk("stallA_imm", bus.out_imm, 5);
        bus.out_ready = 1'b0;
        drive(32'h00A50533, 32'h304);
        #1 chk("stall_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_imm", bus.out_imm, 5);
            chk("stall_pc", bus.out_pc, 32'h300);
            chk("stall_rd", bus.out_rd, 1);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1 chk("release_in_ready", bus.in_ready, 1);
        tick();
        chk("release_valid", bus.out_valid, 1);
        chk("release_rd", bus.out_rd, 10);
        chk("release_pc", bus.out_pc, 32'h304);
        bus.in_valid = 1'b0;
        tick();
        chk("nodup_valid", bus.out_valid, 0);
        chk("nodup_rd_we", bus.out_rd_we, 0);

        // flush during a stall
        drive(32'h00500093, 32'h400);
        tick();
        chk("fl1_pre_valid", bus.out_valid, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        tick();
        chk("fl1_valid", bus.out_valid, 0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // flush concurrent with a valid input
        drive(32'h00A50533, 32'h500);
        bus.flush = 1'b1;
        tick();
        chk("fl2_valid", bus.out_valid, 0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("fl2_dropped", bus.out_valid, 0);

        // reset mid-stream
        drive(32'h12345137, 32'h600);
        tick();
        chk("rst2_pre_valid", bus.out_valid, 1);
        rst = 1'b1;
        tick();
        chk("rst2_valid", bus.out_valid, 0);
        chk("rst2_alu", bus.out_alu_op, 0);
        chk("rst2_a_sel", bus.out_a_sel, 0);
        chk("rst2_imm", bus.out_imm, 0);
        chk("rst2_rd", bus.out_rd, 0);
        chk("rst2_pc", bus.out_pc, 0);
        chk("rst2_rd_we", bus.out_rd_we, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
